// File: rtl/csa_accum_seq_if.sv
// csa_accum_seq_if: beat input, result output and status signals of the carry-save dot-product sequencer
interface csa_accum_seq_if #(
  parameter int W     = 16,
  parameter int BW    = 5,
  parameter int ACC_W = 28
);
  logic [BW-1:0]    cfg_beats;
  logic             in_valid;
  logic             in_ready;
  logic [9*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;
  logic [BW-1:0]    beat_cnt;
  modport master (
    output cfg_beats, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, beat_cnt
  );
  modport slave (
    input  cfg_beats, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, beat_cnt
  );
endinterface

// File: rtl/csa_accum_seq.sv
// csa_accum_seq: time-shares one 11-input carry-save compressor over the beats of a frame,
// then resolves the sum/carry pair with a single ripple add and offers it on a valid/ready port
module csa_accum_seq #(
  parameter int W         = 16,
  parameter int MAX_BEATS = 16,
  parameter int BW        = 5,
  parameter int ACC_W     = 28
) (
  input  logic clk,
  input  logic rst,
  csa_accum_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] sum_r, carry_r, sum_nxt, carry_nxt;
  logic [ACC_W-1:0] op [9];
  logic [ACC_W-1:0] l1 [6];
  logic [ACC_W-1:0] l2 [4];
  logic [ACC_W-1:0] l3 [2];
  logic [ACC_W-1:0] l4 [2];
  logic [ACC_W-1:0] l5 [2];
  logic [BW-1:0] beats_r, beats_cfg, cnt_inc;
  logic accept;
  function automatic logic [2*ACC_W-1:0] csa(input logic [ACC_W-1:0] a, b, c);
    return {a ^ b ^ c, ((a & b) | (a & c) | (b & c)) << 1};
  endfunction
  assign bus.in_ready = (state == IDLE) || (state == ACCUM);
  assign bus.busy     = state != IDLE;
  assign accept       = bus.in_valid & bus.in_ready;
  assign cnt_inc      = bus.beat_cnt + 1'b1;
  assign beats_cfg    = bus.cfg_beats == '0 ? BW'(1)
                      : bus.cfg_beats > BW'(MAX_BEATS) ? BW'(MAX_BEATS) : bus.cfg_beats;
  // 9:2 tree on the operands, then a 4:2 stage folding in the running pair
  always_comb begin
    for (int k = 0; k < 9; k++) op[k] = ACC_W'(bus.in_data[k*W +: W]);
    {l1[0], l1[1]} = csa(op[0], op[1], op[2]);
    {l1[2], l1[3]} = csa(op[3], op[4], op[5]);
    {l1[4], l1[5]} = csa(op[6], op[7], op[8]);
    {l2[0], l2[1]} = csa(l1[0], l1[1], l1[2]);
    {l2[2], l2[3]} = csa(l1[3], l1[4], l1[5]);
    {l3[0], l3[1]} = csa(l2[0], l2[1], l2[2]);
    {l4[0], l4[1]} = csa(l3[0], l3[1], l2[3]);
    {l5[0], l5[1]} = csa(l4[0], l4[1], sum_r);
    {sum_nxt, carry_nxt} = csa(l5[0], l5[1], carry_r);
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = beats_cfg == BW'(1) ? RESOLVE : ACCUM;
      ACCUM:   if (accept && cnt_inc == beats_r) state_nxt = RESOLVE;
      RESOLVE: state_nxt = OUTPUT;
      OUTPUT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  // beat_cnt is zero whenever IDLE, so the shared increment also starts a frame at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r         <= '0;
      carry_r       <= '0;
      beats_r       <= '0;
      bus.beat_cnt  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (accept) begin
        sum_r        <= sum_nxt;
        carry_r      <= carry_nxt;
        bus.beat_cnt <= cnt_inc;
      end
      if (accept && state == IDLE) beats_r <= beats_cfg;
      if (state == RESOLVE) begin
        bus.out_data  <= sum_r + carry_r;
        bus.out_valid <= 1'b1;
      end
      if (state == OUTPUT && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        sum_r         <= '0;
        carry_r       <= '0;
        bus.beat_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_csa_accum_seq.sv
// tb_csa_accum_seq: drives directed and random frames and compares the resolved sums against
// a plain integer model of the dot product
module tb_csa_accum_seq;
  localparam int W = 16, MAX_BEATS = 16, BW = 5, ACC_W = 28;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  csa_accum_seq_if #(.W(W), .BW(BW), .ACC_W(ACC_W)) bus ();
  csa_accum_seq #(.W(W), .MAX_BEATS(MAX_BEATS), .BW(BW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int vectors = 0, miscompares = 0;
  logic [9*W-1:0] beat_q [MAX_BEATS];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [9*W-1:0] fill(input logic [W-1:0] v);
    logic [9*W-1:0] r;
    for (int k = 0; k < 9; k++) r[k*W +: W] = v;
    return r;
  endfunction
  task automatic put_beat(input logic [9*W-1:0] d, input logic [BW-1:0] cfg);
    int n = 0;
    bus.in_data   = d;
    bus.cfg_beats = cfg;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic run_frame(input logic [BW-1:0] cfg, input logic [BW-1:0] cfg_late,
                           input int stall_max, input int hold);
    int nb;
    longint total = 0;
    logic [ACC_W-1:0] exp;
    nb = cfg == 0 ? 1 : (cfg > MAX_BEATS ? MAX_BEATS : int'(cfg));
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(stall_max, 0)) @(negedge clk);
      for (int k = 0; k < 9; k++) total += longint'(beat_q[i][k*W +: W]);
      put_beat(beat_q[i], i == 0 ? cfg : cfg_late);
      chk("beat_cnt", bus.beat_cnt, i + 1);
    end
    exp = ACC_W'(total);
    chk("in_ready_resolve", bus.in_ready, 0);
    chk("out_valid_resolve", bus.out_valid, 0);
    @(negedge clk);
    chk("out_valid_output", bus.out_valid, 1);
    chk("out_data", bus.out_data, exp);
    chk("in_ready_output", bus.in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      bus.cfg_beats = BW'($urandom);
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, exp);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_beat_cnt", bus.beat_cnt, nb);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_done", bus.out_valid, 0);
    chk("busy_done", bus.busy, 0);
    chk("beat_cnt_done", bus.beat_cnt, 0);
    chk("in_ready_done", bus.in_ready, 1);
    chk("out_data_kept", bus.out_data, exp);
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_beat_cnt"}, bus.beat_cnt, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.cfg_beats = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    beat_q[0] = fill(16'hFFFF);
    run_frame(1, 1, 0, 0);
    beat_q[0] = fill(16'd1);
    beat_q[1] = fill(16'd2);
    beat_q[2] = fill(16'd3);
    beat_q[2][7*W +: 2*W] = '0;
    run_frame(3, 3, 0, 0);
    for (int i = 0; i < MAX_BEATS; i++) beat_q[i] = fill(16'hFFFF);
    run_frame(16, 16, 0, 0);
    run_frame(16, 16, 3, 0);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 9; k++) beat_q[i][k*W +: W] = W'($urandom);
    run_frame(2, 2, 0, 5);
    run_frame(3, 3, 0, 0);
    for (int i = 0; i < 3; i++) beat_q[i] = fill(16'd1);
    put_beat(beat_q[0], 3);
    put_beat(beat_q[1], 3);
    chk("pre_reset_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(3, 3, 0, 0);
    beat_q[0] = fill(16'd7);
    run_frame(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) beat_q[i] = fill(16'(i + 4));
    run_frame(3, 2, 1, 0);
    for (int i = 0; i < MAX_BEATS; i++) beat_q[i] = fill(16'(i * 1000 + 1));
    run_frame(20, 1, 0, 1);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < MAX_BEATS; i++)
        for (int k = 0; k < 9; k++) beat_q[i][k*W +: W] = W'($urandom);
      run_frame(BW'($urandom_range(20, 0)), BW'($urandom), 3, int'($urandom_range(3, 0)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
